// File: rtl/dino_pkg.sv
// Shared constants and types for the dino game pixel pipeline.
// Screen geometry, obstacle heights, LFSR setup and the game state encoding.
package dino_pkg;

    localparam int unsigned SCREEN_W    = 640;
    localparam int unsigned SCREEN_H    = 480;
    localparam int unsigned GROUND_Y    = 400;
    localparam int unsigned OBS_H_TALL  = 40;
    localparam int unsigned OBS_H_SHORT = 24;

    // Bit i set means stage i+1 feeds back: x^8 + x^6 + x^5 + x^4 + 1.
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HALT
    } game_state_t;

    typedef struct packed {
        logic       valid;
        logic [9:0] x;
        logic       tall;
    } obstacle_t;

    // First row covered by an obstacle of the given height class.
    function automatic logic [9:0] obs_top(input logic tall);
        return tall ? 10'(GROUND_Y - OBS_H_TALL) : 10'(GROUND_Y - OBS_H_SHORT);
    endfunction

endpackage

// File: rtl/obstacle_gen_lfsr8.sv
// 8-bit Fibonacci LFSR used to randomise obstacle spacing and height.
// Shifts towards the MSB; the feedback bit enters at bit 0.
module lfsr8
    import dino_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    // NOTE: registers update with <= so every flop samples pre-edge values, whatever the block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= LFSR_SEED;
        end else if (en) begin
            q <= {q[6:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/obstacle_gen.sv
// Obstacle field for the dino game: two scrolling cactus slots, spawn pacing,
// IDLE/RUN/HALT game state and a registered per-pixel obstacle hit.
module obstacle_gen
    import dino_pkg::*;
#(
    parameter int unsigned OBS_W   = 16,
    parameter int unsigned SPEED   = 4,
    parameter int unsigned SPAWN_X = SCREEN_W,
    parameter int unsigned MIN_GAP = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_game_tick_20hz,
    input  logic       i_game_start_pulse,
    input  logic       i_collision,
    output logic       o_color_obstacle,
    output logic       o_running
);

    game_state_t state;
    logic [6:0]  gap_cnt;
    logic [6:0]  gap_seed;
    logic [7:0]  lfsr_q;
    logic        tick_run;
    logic        spawn;
    logic        spawn_idx;
    logic [1:0]  moved_valid;
    logic [1:0]  hit;
    logic        unused_lfsr_bits;

    // Start beats everything; a collision swallows a coincident tick.
    assign tick_run = i_game_tick_20hz && (state == ST_RUN)
                      && !i_game_start_pulse && !i_collision;

    assign gap_seed         = 7'(MIN_GAP) + 7'(lfsr_q[4:0]);
    assign spawn            = tick_run && (gap_cnt == 7'd0) && !(&moved_valid);
    assign spawn_idx        = moved_valid[0];
    assign unused_lfsr_bits = ^lfsr_q[6:5];

    lfsr8 u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (tick_run),
        .q   (lfsr_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            o_running <= 1'b0;
            gap_cnt   <= '0;
        end else if (i_game_start_pulse) begin
            state     <= ST_RUN;
            o_running <= 1'b1;
            gap_cnt   <= gap_seed;
        end else if (state == ST_RUN && i_collision) begin
            state     <= ST_HALT;
            o_running <= 1'b0;
        end else if (tick_run) begin
            if (gap_cnt != 7'd0) begin
                gap_cnt <= gap_cnt - 7'd1;
            end else if (spawn) begin
                gap_cnt <= gap_seed;
            end
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        obstacle_t slot;
        logic      expired;

        assign expired        = slot.x < 10'(SPEED);
        assign moved_valid[i] = slot.valid && !expired;

        // A slot spawned on this tick keeps SPAWN_X until the next tick.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                slot <= '0;
            end else if (i_game_start_pulse) begin
                slot <= '0;
            end else if (tick_run) begin
                if (spawn && spawn_idx == 1'(i)) begin
                    slot <= '{valid: 1'b1, x: 10'(SPAWN_X), tall: lfsr_q[7]};
                end else begin
                    slot.valid <= moved_valid[i];
                    if (moved_valid[i]) begin
                        slot.x <= slot.x - 10'(SPEED);
                    end
                end
            end
        end

        // Horizontal test at 11 bits so x + OBS_W cannot wrap.
        assign hit[i] = slot.valid
                        && ({1'b0, i_hpos} >= {1'b0, slot.x})
                        && ({1'b0, i_hpos} <  {1'b0, slot.x} + 11'(OBS_W))
                        && (i_vpos >= obs_top(slot.tall))
                        && (i_vpos <  10'(GROUND_Y));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_color_obstacle <= 1'b0;
        end else begin
            o_color_obstacle <= |hit;
        end
    end

endmodule

// File: tb/tb_obstacle_gen.sv
// Randomised bench for obstacle_gen against an abstract model of the obstacle field.
module tb_obstacle_gen;

    localparam int GROUND  = 400;
    localparam int W       = 16;
    localparam int STEP    = 4;
    localparam int SPAWN   = 640;
    localparam int GAP_MIN = 24;

    logic       clk = 1'b0;
    bit         clk_en = 1'b0;
    logic       rst;
    logic [9:0] hpos, vpos;
    logic       tick, start, coll;
    logic       color, running;

    obstacle_gen dut (
        .clk                (clk),
        .rst                (rst),
        .i_hpos             (hpos),
        .i_vpos             (vpos),
        .i_game_tick_20hz   (tick),
        .i_game_start_pulse (start),
        .i_collision        (coll),
        .o_color_obstacle   (color),
        .o_running          (running)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Abstract model: game is running or not, two obstacles with plain int positions.
    bit         m_running;
    bit         m_valid [2];
    int         m_x     [2];
    bit         m_tall  [2];
    int         m_gap;
    logic [7:0] m_lfsr;

    bit   coll_lvl;
    bit   exp_on;
    logic exp_pix, exp_run;
    int   exp_h, exp_v;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, want);
        end
    endtask

    // Polynomial x^8+x^6+x^5+x^4+1, new bit shifted in at the bottom.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int height(input bit tall);
        return tall ? 40 : 24;
    endfunction

    function automatic bit model_pixel(input int h, input int v);
        for (int k = 0; k < 2; k++)
            if (m_valid[k] && h >= m_x[k] && h < m_x[k] + W &&
                v >= GROUND - height(m_tall[k]) && v < GROUND)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_running = 0;
        m_gap     = 0;
        m_lfsr    = 8'hA5;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0; m_x[k] = 0; m_tall[k] = 0;
        end
    endtask

    task automatic model_update(input bit s, input bit t, input bit c);
        int free_k;
        if (s) begin
            m_running = 1;
            for (int k = 0; k < 2; k++) m_valid[k] = 0;
            m_gap = GAP_MIN + int'(m_lfsr[4:0]);
        end else if (m_running && c) begin
            m_running = 0;
        end else if (m_running && t) begin
            for (int k = 0; k < 2; k++)
                if (m_valid[k]) begin
                    if (m_x[k] < STEP) m_valid[k] = 0;
                    else m_x[k] -= STEP;
                end
            if (m_gap > 0) begin
                m_gap--;
            end else begin
                free_k = -1;
                for (int k = 1; k >= 0; k--)
                    if (!m_valid[k]) free_k = k;
                if (free_k >= 0) begin
                    m_valid[free_k] = 1;
                    m_x[free_k]     = SPAWN;
                    m_tall[free_k]  = m_lfsr[7];
                    m_gap           = GAP_MIN + int'(m_lfsr[4:0]);
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    // One clock: expected output comes from the obstacle field as it was before this edge.
    task automatic cycle(input bit s, input bit t, input bit c, input int h, input int v);
        logic e;
        e = model_pixel(h, v);
        model_update(s, t, c);
        start = s; tick = t; coll = c;
        hpos = 10'(h); vpos = 10'(v);
        @(posedge clk);
        exp_pix = e; exp_run = m_running; exp_h = h; exp_v = v; exp_on = 1;
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_on) begin
            check($sformatf("pixel(%0d,%0d)", exp_h, exp_v), color, exp_pix);
            check("running", running, exp_run);
        end
    end

    task automatic pick(output int h, output int v);
        int k;
        k = $urandom_range(0, 1);
        if ($urandom_range(0, 1) == 1 && m_valid[k]) begin
            h = m_x[k] + int'($urandom_range(0, 24)) - 4;
            if (h < 0) h = 0;
            v = $urandom_range(350, 405);
        end else begin
            h = $urandom_range(0, 799);
            v = $urandom_range(0, 524);
        end
    endtask

    task automatic tick_n(input int n);
        int h, v;
        repeat (n) begin
            pick(h, v);
            cycle(0, 1, coll_lvl, h, v);
            repeat ($urandom_range(1, 3)) begin
                pick(h, v);
                cycle(0, 0, coll_lvl, h, v);
            end
        end
    endtask

    task automatic probe(input string name, input int h, input int v, input bit want);
        cycle(0, 0, coll_lvl, h, v);
        check(name, color, want);
    endtask

    task automatic probe_slot(input int k);
        int x, top;
        x   = m_x[k];
        top = GROUND - height(m_tall[k]);
        probe("edge_top_row", x, top, 1);
        probe("edge_right_col", x + 15, GROUND - 1, 1);
        probe("past_right_col", x + 16, GROUND - 1, 0);
        probe("above_top_row", x, top - 1, 0);
    endtask

    function automatic int find_valid();
        for (int k = 0; k < 2; k++)
            if (m_valid[k]) return k;
        return -1;
    endfunction

    initial begin
        int  h, v, k, sx;
        bit  found, s;

        rst = 0; start = 0; tick = 0; coll = 0; hpos = 0; vpos = 0;
        coll_lvl = 0; exp_on = 0;
        #1 rst = 1;
        #1;
        check("reset_pix_noclk", color, 0);
        check("reset_run_noclk", running, 0);
        clk_en = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        model_reset();

        // Idle: ticks and collisions alone must never produce obstacles.
        tick_n(100);
        cycle(0, 0, 1, 100, 390);
        probe("idle_no_obstacle", 640, 390, 0);

        // First spawn after 29 countdown ticks.
        cycle(1, 0, 0, 0, 0);
        check("gap_after_start", m_gap, 29);
        check("running_after_start", running, 1);
        tick_n(29);
        probe("no_spawn_before_30th", 640, 390, 0);
        tick_n(1);
        probe("spawn_at_640", 640, 390, 1);
        check("model_spawn_x", m_x[0], 640);
        tick_n(10);
        check("model_x_after_10", m_x[0], 600);
        probe("slot0_at_600", 600, 399, 1);
        probe("left_of_600", 599, 399, 0);

        // Despawn with a deferred spawn landing on the same tick.
        tick_n(150);
        check("model_x_at_0", m_x[0], 0);
        check("model_gap_waiting", m_gap, 0);
        check("model_slot1_valid", m_valid[1], 1);
        probe("slot0_at_0", 0, 399, 1);
        probe("slot0_at_0_right", 15, 399, 1);
        tick_n(1);
        check("model_respawn_x", m_x[0], 640);
        for (int i = 0; i < 16; i++) probe("after_despawn", i, 399, 0);
        probe("deferred_spawn", 640, 399, 1);

        // Height and horizontal edges, including a slot passing x=100.
        found = 0;
        for (int n = 0; n < 400 && !found; n++) begin
            tick_n(1);
            for (int j = 0; j < 2; j++)
                if (m_valid[j] && m_x[j] == 100 && !found) begin
                    probe_slot(j);
                    found = 1;
                end
            if (n % 7 == 0) begin
                k = find_valid();
                if (k >= 0) probe_slot(k);
            end
        end
        check("slot_reached_x100", found, 1);

        // Collision with a coincident tick, then frozen field across 20 ticks.
        k = find_valid();
        check("have_slot_for_collision", k >= 0, 1);
        sx = (k >= 0) ? m_x[k] : 0;
        cycle(0, 1, 1, 0, 0);
        check("halt_running", running, 0);
        coll_lvl = 1;
        tick_n(20);
        probe("frozen_right_col", sx + 15, 399, 1);
        probe("frozen_left_col", sx, 399, 1);
        coll_lvl = 0;
        cycle(1, 0, 0, 0, 0);
        check("restart_running", running, 1);
        probe("restart_clears", sx + 15, 399, 0);

        // Start and tick together: restart only.
        tick_n(70);
        k = find_valid();
        check("have_slot_for_restart", k >= 0, 1);
        sx = (k >= 0) ? m_x[k] : 0;
        cycle(1, 1, 0, sx, 399);
        check("start_tick_running", running, 1);
        probe("start_tick_clears", sx, 399, 0);

        // Random mix of restarts, collisions and ticks.
        for (int n = 0; n < 400; n++) begin
            s = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) coll_lvl = !coll_lvl;
            pick(h, v);
            cycle(s, 1, coll_lvl, h, v);
            repeat ($urandom_range(1, 3)) begin
                pick(h, v);
                cycle(0, 0, coll_lvl, h, v);
            end
            if (n % 11 == 0) begin
                k = find_valid();
                if (k >= 0) probe_slot(k);
            end
        end

        // Asynchronous reset mid-frame with the clock stopped.
        coll_lvl = 0;
        cycle(1, 0, 0, 0, 0);
        tick_n(60);
        k = find_valid();
        check("have_slot_for_reset", k >= 0, 1);
        sx = (k >= 0) ? m_x[k] : 0;
        probe("pre_reset_hit", sx, 399, 1);
        exp_on = 0;
        @(negedge clk);
        clk_en = 0;
        #2 rst = 1;
        #1;
        check("async_reset_pix", color, 0);
        check("async_reset_run", running, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
